// File: rtl/keccak_squeezer_if.sv
// Load/stream bundle for the Keccak digest squeezer: digest load in, word stream out.
interface keccak_squeezer_if #(parameter int W = 64);
  logic [1:0]     mode;
  logic [8*W-1:0] digest_in;
  logic           load_valid;
  logic           load_ready;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [W/8-1:0] out_keep;
  logic           done;

  modport master (
    output mode, digest_in, load_valid, out_ready,
    input  load_ready, out, out_valid, out_last, out_keep, done
  );

  modport slave (
    input  mode, digest_in, load_valid, out_ready,
    output load_ready, out, out_valid, out_last, out_keep, done
  );
endinterface

// File: rtl/keccak_squeezer.sv
// Captures the final Keccak lanes and streams the SHA3 digest one lane per beat,
// trimming the last word for SHA3-224.
module keccak_squeezer #(
  parameter int W = 64
) (
  input logic               clk,
  input logic               rst,
  keccak_squeezer_if.slave  bus
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state, state_nxt;
  logic [NUM_LANES-1:0][W-1:0]  lane_q;
  logic [1:0]                   mode_q;
  logic [2:0]                   idx;
  logic [2:0]                   last_idx;
  logic                         done_q;
  logic                         load_acc, xfer, is_last;

  assign load_acc = bus.load_valid & bus.load_ready;
  assign xfer     = bus.out_valid & bus.out_ready;
  assign is_last  = (idx == last_idx);

  always_comb begin
    last_idx = 3'd3;
    case (mode_q)
      2'd0:    last_idx = 3'd7;
      2'd1:    last_idx = 3'd5;
      default: last_idx = 3'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_acc) state_nxt = SEND;
      SEND:    if (xfer && is_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane i of digest_in lines up exactly with lane_q[i], so one wide capture suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      mode_q <= '0;
    end else if (load_acc) begin
      lane_q <= bus.digest_in;
      mode_q <= bus.mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   idx <= '0;
    else if (load_acc)         idx <= '0;
    else if (xfer && !is_last) idx <= idx + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= xfer & is_last;
  end

  // Holding load_ready low during the done pulse keeps a back-to-back load
  // from landing before downstream has seen completion.
  always_comb begin
    bus.out        = '0;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.out_keep   = '0;
    bus.done       = done_q;
    bus.load_ready = (state == IDLE) && !done_q;
    if (state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_last  = is_last;
      bus.out       = lane_q[idx];
      bus.out_keep  = '1;
      if (is_last && mode_q == 2'd3) begin
        bus.out[W-1:W/2] = '0;
        bus.out_keep     = {{(W/16){1'b0}}, {(W/16){1'b1}}};
      end
    end
  end
endmodule

// File: tb/tb_keccak_squeezer.sv
// Directed bench for keccak_squeezer: reset, per-mode streaming, stalls, load blocking, reset abort.
module tb_keccak_squeezer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_squeezer_if #(.W(64)) bus();
  keccak_squeezer #(.W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [511:0] dig_a, dig_b, dig_c;

  // lane k of dig_a is hex digit (k+1) repeated; lane k of dig_b is byte A0+k repeated
  function automatic logic [63:0] exp_a(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k + 1);
  endfunction

  function automatic logic [63:0] exp_b(input int k);
    return 64'h0101_0101_0101_0101 * 64'(160 + k);
  endfunction

  task automatic load(input logic [1:0] m, input logic [511:0] d);
    bus.mode       = m;
    bus.digest_in  = d;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out, bus.done} !== 75'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.out_valid, bus.out_last, bus.out_keep, bus.out, bus.done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.load_ready, bus.done} !== 2'b10) begin
      failures++;
      $display("FAIL reset_load_ready: got %b expected 10", {bus.load_ready, bus.done});
    end
  endtask

  task automatic test_mode2_stream();
    bus.out_ready = 1'b1;
    load(2'd2, dig_a);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out} !== {1'b1, 1'(k == 3), 8'hFF, exp_a(k)}) begin
        failures++;
        $display("FAIL mode2_word%0d: got %h expected %h", k,
                 {bus.out_valid, bus.out_last, bus.out_keep, bus.out}, {1'b1, 1'(k == 3), 8'hFF, exp_a(k)});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.out_valid, bus.done, bus.load_ready} !== 3'b010) begin
      failures++;
      $display("FAIL mode2_done: got %b expected 010", {bus.out_valid, bus.done, bus.load_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.load_ready} !== 2'b01) begin
      failures++;
      $display("FAIL mode2_after_done: got %b expected 01", {bus.done, bus.load_ready});
    end
  endtask

  task automatic test_mode3_keep();
    logic [63:0] ew;
    logic [7:0]  ek;
    bus.out_ready = 1'b1;
    load(2'd3, dig_c);
    for (int k = 0; k < 4; k++) begin
      ew = (k == 3) ? 64'h0000_0000_CAFE_F00D : exp_a(k);
      ek = (k == 3) ? 8'h0F : 8'hFF;
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out} !== {1'b1, 1'(k == 3), ek, ew}) begin
        failures++;
        $display("FAIL mode3_word%0d: got %h expected %h", k,
                 {bus.out_valid, bus.out_last, bus.out_keep, bus.out}, {1'b1, 1'(k == 3), ek, ew});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.out_valid, bus.done} !== 2'b01) begin
      failures++;
      $display("FAIL mode3_done: got %b expected 01", {bus.out_valid, bus.done});
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int pat[4] = '{1, 0, 0, 1};
    int idx = 0;
    int cyc = 0;
    load(2'd0, dig_a);
    while (idx < 8 && cyc < 64) begin
      bus.out_ready = 1'(pat[cyc % 4]);
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out} !== {1'b1, 1'(idx == 7), 8'hFF, exp_a(idx)}) begin
        failures++;
        $display("FAIL stall_cyc%0d_idx%0d: got %h expected %h", cyc, idx,
                 {bus.out_valid, bus.out_last, bus.out_keep, bus.out}, {1'b1, 1'(idx == 7), 8'hFF, exp_a(idx)});
      end
      if (pat[cyc % 4] == 1) idx++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ({bus.out_valid, bus.done} !== 2'b01 || idx != 8) begin
      failures++;
      $display("FAIL stall_end: got valid/done %b after %0d words, expected 01 after 8",
               {bus.out_valid, bus.done}, idx);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignore_load();
    bus.out_ready = 1'b1;
    load(2'd1, dig_a);
    bus.mode       = 2'd0;
    bus.digest_in  = dig_b;
    bus.load_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.load_ready, bus.out_valid, bus.out_last, bus.out_keep, bus.out} !==
          {1'b0, 1'b1, 1'(k == 5), 8'hFF, exp_a(k)}) begin
        failures++;
        $display("FAIL ignore_word%0d: got %h expected %h", k,
                 {bus.load_ready, bus.out_valid, bus.out_last, bus.out_keep, bus.out},
                 {1'b0, 1'b1, 1'(k == 5), 8'hFF, exp_a(k)});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.out_valid, bus.done, bus.load_ready} !== 3'b010) begin
      failures++;
      $display("FAIL ignore_done: got %b expected 010", {bus.out_valid, bus.done, bus.load_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.done, bus.load_ready} !== 3'b001) begin
      failures++;
      $display("FAIL ignore_reload_ready: got %b expected 001", {bus.out_valid, bus.done, bus.load_ready});
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out} !== {1'b1, 1'(k == 7), exp_b(k)}) begin
        failures++;
        $display("FAIL reload_word%0d: got %h expected %h", k,
                 {bus.out_valid, bus.out_last, bus.out}, {1'b1, 1'(k == 7), exp_b(k)});
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL reload_done: got %b expected 1", bus.done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bus.out_ready = 1'b1;
    load(2'd0, dig_a);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out, bus.done} !== 75'd0) begin
      failures++;
      $display("FAIL abort_outputs: got %h expected 0",
               {bus.out_valid, bus.out_last, bus.out_keep, bus.out, bus.done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.load_ready, bus.out_valid} !== 3'b010) begin
      failures++;
      $display("FAIL abort_idle: got %b expected 010", {bus.done, bus.load_ready, bus.out_valid});
    end
    load(2'd2, dig_b);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_keep, bus.out} !== {1'b1, 1'(k == 3), 8'hFF, exp_b(k)}) begin
        failures++;
        $display("FAIL abort_reload_word%0d: got %h expected %h", k,
                 {bus.out_valid, bus.out_last, bus.out_keep, bus.out}, {1'b1, 1'(k == 3), 8'hFF, exp_b(k)});
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL abort_reload_done: got %b expected 1", bus.done);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      dig_a[i*64 +: 64] = {16{4'(i + 1)}};
      dig_b[i*64 +: 64] = {8{8'(160 + i)}};
    end
    dig_c = dig_a;
    dig_c[3*64 +: 64] = 64'hDEAD_BEEF_CAFE_F00D;

    rst            = 1'b1;
    bus.mode       = 2'd0;
    bus.digest_in  = '0;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;

    test_reset();
    test_mode2_stream();
    test_mode3_keep();
    test_stall();
    test_ignore_load();
    test_reset_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
